pdec_srt_sched: RTL and testbench
=================================

Name: pdec_srt_sched

Overview:
- Leaf-level scheduler for the shared PM sorter in the SCL polar decoder.
- Accepts one leaf-node request at a time from the tree-walk controller and tracks the active list size.
- Derives the sorter configuration (sort_num, path_valid, cur_jump_type) and sequences the handshake PM-update -> sort-start -> sort-done.
- Reports leaf completion and the new list size; flags sorter timeouts.

Parameters:
- LIST_MAX, 8, maximum list size; legal values 1, 2, 4, 8.
- TO_CYC, 64, cycles allowed between sort start and sort done before timeout.
- WID_TO, 7, width of the timeout counter; must satisfy 2^WID_TO > TO_CYC.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frm_st  in  1  frame start pulse; forces list size to 1
- leaf_req  in  1  leaf request; held high until leaf_ack
- leaf_jump_type  in  3  0 frozen, 1 rep (2 candidates/path), 2 info (4 candidates/path); others illegal
- leaf_ack  out  1  one-cycle accept pulse
- leaf_done  out  1  one-cycle completion pulse
- act_path_num  out  4  current active list size (1..LIST_MAX)
- ctrl2upm_req  out  1  one-cycle pulse requesting candidate PM computation
- upm2ctrl_pm_vld  in  1  candidate PMs valid on the sorter input bus this cycle
- cur_jump_type  out  3  to sorter
- sort_num  out  3  to sorter: 0 sort2, 1 sort4, 2 sort8, 3 sort16, 4 sort32
- path_valid  out  16  to sorter; 2 bits per path: 1 valid, 3 invalid
- ctrl2srt_srt_st  out  1  sort start, aligned with the PM bus
- srt2ctrl_srt_done  in  1  sort complete
- err_to  out  1  sticky sorter-timeout flag
- err_jt  out  1  sticky illegal-jump-type flag

Behaviour:
- Reset values: all pulses 0; act_path_num=1; sort_num=0; cur_jump_type=0; path_valid=16'hFFFF; err_to=0; err_jt=0; FSM in IDLE.
- FSM states: IDLE, WAIT_PM, SORT, FIN.
- IDLE: on leaf_req=1, pulse leaf_ack and latch leaf_jump_type into cur_jump_type.
  - Frozen or illegal type: go to FIN. An illegal type also sets err_jt.
  - Rep or info type: pulse ctrl2upm_req and go to WAIT_PM.
- Configuration registered at accept, held stable until leaf_done. Let A = act_path_num.
  - cand = 2*A for rep, 4*A for info.
  - sort_num = log2(cand)-1.
  - path_valid[2i+:2] = 1 for i<A, else 3.
- WAIT_PM: ctrl2srt_srt_st = upm2ctrl_pm_vld, combinational and gated by the state. This gives zero-cycle alignment with the PM bus. On pm_vld, clear the timeout counter and go to SORT.
- SORT: the counter increments each cycle.
  - On srt2ctrl_srt_done: act_path_num <= min(cand, LIST_MAX), then go to FIN.
  - If the counter reaches TO_CYC first: set err_to, leave act_path_num unchanged, go to FIN.
  - Done and timeout in the same cycle: done wins and err_to is not set.
- FIN: pulse leaf_done, return to IDLE. A new leaf_req is not acked in FIN. Minimum spacing between acks is 2 cycles.
- Frozen leaf latency: ack at cycle t, done at t+1.
- Sort leaf latency: ack at t, upm_req at t, srt_st in the pm_vld cycle, leaf_done one cycle after srt_done.
- frm_st: act_path_num=1 and both error flags cleared.
  - In any non-IDLE state the FSM aborts to IDLE without leaf_done.
  - If frm_st and srt_done coincide, frm_st wins.
  - frm_st in IDLE while leaf_req=1: reset only; the request is acked next cycle.
- srt_done outside SORT, and pm_vld outside WAIT_PM, are ignored.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Test Plan:
- Reset, then frm_st; info leaf with A=1 -> sort_num=1, path_valid=16'hFFFD, srt_st coincident with pm_vld; after done, act_path_num=4 and leaf_done one cycle after srt_done.
- Second info leaf with A=4 -> sort_num=3, path_valid=16'hFF55; act_path_num becomes 8 (capped at LIST_MAX).
- Info leaf with A=8 -> sort_num=4, path_valid=16'h5555; act_path_num stays 8. Rep leaf with A=8 -> sort_num=3.
- Frozen leaf -> no upm_req, no srt_st, leaf_done at ack+1, act_path_num unchanged. Jump type 5 -> same flow plus err_jt=1.
- Withhold srt_done -> err_to=1 after 64 SORT cycles, then leaf_done, act_path_num unchanged. Done on exactly the 64th cycle -> err_to stays 0.
- frm_st during SORT -> FSM returns to IDLE, no leaf_done, act_path_num=1. Back-to-back leaf_req -> acks spaced at least 2 cycles apart.

Source files
------------

// File: rtl/pdec_srt_sched.sv
// Leaf-level scheduler for the shared PM sorter of the SCL polar decoder.
// Sequences PM-update -> sort-start -> sort-done per leaf and tracks the active list size.
module pdec_srt_sched #(
    parameter int LIST_MAX = 8,
    parameter int TO_CYC   = 64,
    parameter int WID_TO   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_st,
    input  logic        leaf_req,
    input  logic [2:0]  leaf_jump_type,
    output logic        leaf_ack,
    output logic        leaf_done,
    output logic [3:0]  act_path_num,
    output logic        ctrl2upm_req,
    input  logic        upm2ctrl_pm_vld,
    output logic [2:0]  cur_jump_type,
    output logic [2:0]  sort_num,
    output logic [15:0] path_valid,
    output logic        ctrl2srt_srt_st,
    input  logic        srt2ctrl_srt_done,
    output logic        err_to,
    output logic        err_jt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PM,
        SORT,
        FIN
    } state_t;

    localparam logic [WID_TO-1:0] TO_LIM = WID_TO'(TO_CYC);

    state_t            state;
    state_t            state_nxt;
    logic [WID_TO-1:0] to_cnt;
    logic [WID_TO-1:0] to_cnt_inc;
    logic [3:0]        act_after_sort;
    logic              jt_sort;
    logic              jt_bad;
    logic              timeout_hit;
    logic [2:0]        a_log;
    logic [2:0]        sort_num_calc;
    logic [5:0]        cand;
    logic [3:0]        cand_clip;
    logic [15:0]       pv_calc;

    // Sorter configuration derived from the current list size; the list size is always a power of two.
    always_comb begin
        a_log = 3'd0;
        case (act_path_num)
            4'd2:    a_log = 3'd1;
            4'd4:    a_log = 3'd2;
            4'd8:    a_log = 3'd3;
            default: a_log = 3'd0;
        endcase
        jt_sort       = (leaf_jump_type == 3'd1) || (leaf_jump_type == 3'd2);
        jt_bad        = (leaf_jump_type > 3'd2);
        sort_num_calc = a_log + ((leaf_jump_type == 3'd2) ? 3'd1 : 3'd0);
        cand          = 6'd2 << sort_num_calc;
        cand_clip     = (int'(cand) > LIST_MAX) ? 4'(LIST_MAX) : cand[3:0];
        pv_calc       = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            pv_calc[2*i +: 2] = (i < int'(act_path_num)) ? 2'b01 : 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A timeout fires on the TO_CYC-th SORT cycle unless the sorter finishes in that same cycle.
    always_comb begin
        state_nxt       = state;
        leaf_ack        = 1'b0;
        leaf_done       = 1'b0;
        ctrl2upm_req    = 1'b0;
        ctrl2srt_srt_st = 1'b0;
        timeout_hit     = 1'b0;
        to_cnt_inc      = to_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (leaf_req && !frm_st) begin
                    leaf_ack = 1'b1;
                    if (jt_sort) begin
                        ctrl2upm_req = 1'b1;
                        state_nxt    = WAIT_PM;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            WAIT_PM: begin
                ctrl2srt_srt_st = upm2ctrl_pm_vld;
                if (upm2ctrl_pm_vld) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                if (srt2ctrl_srt_done) begin
                    state_nxt = FIN;
                end else if (to_cnt_inc == TO_LIM) begin
                    timeout_hit = 1'b1;
                    state_nxt   = FIN;
                end
            end
            FIN: begin
                leaf_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (frm_st) begin
            state_nxt = IDLE;
            leaf_done = 1'b0;
        end
    end

    // Frame start outranks every other update of the list size and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt         <= '0;
            act_path_num   <= 4'd1;
            act_after_sort <= 4'd1;
            cur_jump_type  <= 3'd0;
            sort_num       <= 3'd0;
            path_valid     <= 16'hFFFF;
            err_to         <= 1'b0;
            err_jt         <= 1'b0;
        end else begin
            if (state == WAIT_PM && upm2ctrl_pm_vld) begin
                to_cnt <= '0;
            end else if (state == SORT) begin
                to_cnt <= to_cnt_inc;
            end
            if (leaf_ack) begin
                cur_jump_type <= leaf_jump_type;
                if (jt_sort) begin
                    sort_num       <= sort_num_calc;
                    path_valid     <= pv_calc;
                    act_after_sort <= cand_clip;
                end
            end
            if (frm_st) begin
                act_path_num <= 4'd1;
                err_to       <= 1'b0;
                err_jt       <= 1'b0;
            end else begin
                if (state == SORT && srt2ctrl_srt_done) begin
                    act_path_num <= act_after_sort;
                end
                if (timeout_hit) begin
                    err_to <= 1'b1;
                end
                if (leaf_ack && jt_bad) begin
                    err_jt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdec_srt_sched.sv
// Directed bench for pdec_srt_sched: a scoreboard of expected leaf completions is filled
// at each accept and drained whenever the scheduler reports leaf_done.
module tb_pdec_srt_sched;

    logic        clk;
    logic        rst_n;
    logic        frm_st;
    logic        leaf_req;
    logic [2:0]  leaf_jump_type;
    logic        leaf_ack;
    logic        leaf_done;
    logic [3:0]  act_path_num;
    logic        ctrl2upm_req;
    logic        upm2ctrl_pm_vld;
    logic [2:0]  cur_jump_type;
    logic [2:0]  sort_num;
    logic [15:0] path_valid;
    logic        ctrl2srt_srt_st;
    logic        srt2ctrl_srt_done;
    logic        err_to;
    logic        err_jt;

    typedef struct packed {
        logic [3:0] act;
        logic       eto;
        logic       ejt;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_act    = 4'd1;
    logic       m_err_to = 1'b0;
    logic       m_err_jt = 1'b0;

    pdec_srt_sched #(.LIST_MAX(8), .TO_CYC(64), .WID_TO(7)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frm_st            (frm_st),
        .leaf_req          (leaf_req),
        .leaf_jump_type    (leaf_jump_type),
        .leaf_ack          (leaf_ack),
        .leaf_done         (leaf_done),
        .act_path_num      (act_path_num),
        .ctrl2upm_req      (ctrl2upm_req),
        .upm2ctrl_pm_vld   (upm2ctrl_pm_vld),
        .cur_jump_type     (cur_jump_type),
        .sort_num          (sort_num),
        .path_valid        (path_valid),
        .ctrl2srt_srt_st   (ctrl2srt_srt_st),
        .srt2ctrl_srt_done (srt2ctrl_srt_done),
        .err_to            (err_to),
        .err_jt            (err_jt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven one time unit after the rising edge and sampled a unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input logic [3:0] act, input logic eto, input logic ejt);
        exp_t e;
        e.act = act;
        e.eto = eto;
        e.ejt = ejt;
        sb.push_back(e);
    endtask

    // Completion scoreboard: every leaf_done must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && leaf_done) begin
            checkOutput("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_act", act_path_num, e.act);
                checkOutput("sb_err_to", err_to, e.eto);
                checkOutput("sb_err_jt", err_jt, e.ejt);
            end
        end
    end

    // Rep/info leaf: pm_wait idle cycles in WAIT_PM, then sort_cycles SORT cycles, done on the last
    // one when give_done is set (otherwise the sorter is left to time out after 64 cycles).
    task automatic applyStimulus(input logic [2:0] jt, input int pm_wait, input int sort_cycles,
                                 input bit give_done);
        int          cand;
        logic [2:0]  e_sort;
        logic [15:0] e_pv;
        logic [3:0]  e_act;
        cand   = ((jt == 3'd1) ? 2 : 4) * int'(m_act);
        e_sort = 3'($clog2(cand) - 1);
        for (int i = 0; i < 8; i++) begin
            e_pv[2*i +: 2] = (i < int'(m_act)) ? 2'b01 : 2'b11;
        end
        e_act = give_done ? 4'((cand > 8) ? 8 : cand) : m_act;
        if (!give_done) m_err_to = 1'b1;

        leaf_req       = 1'b1;
        leaf_jump_type = jt;
        #1;
        checkOutput("sort_ack", leaf_ack, 1);
        checkOutput("sort_upm_req", ctrl2upm_req, 1);
        pushExpected(e_act, m_err_to, m_err_jt);
        m_act = e_act;

        cyc();
        leaf_req = 1'b0;
        #1;
        checkOutput("sort_num", sort_num, e_sort);
        checkOutput("path_valid", path_valid, e_pv);
        checkOutput("cur_jump_type", cur_jump_type, jt);
        checkOutput("upm_req_single", ctrl2upm_req, 0);
        checkOutput("srt_st_idle_bus", ctrl2srt_srt_st, 0);
        repeat (pm_wait) cyc();

        upm2ctrl_pm_vld = 1'b1;
        #1;
        checkOutput("srt_st_align", ctrl2srt_srt_st, 1);
        cyc();
        upm2ctrl_pm_vld = 1'b0;

        for (int n = 1; n <= sort_cycles; n++) begin
            if (n == 1) begin
                upm2ctrl_pm_vld = 1'b1;
                #1;
                checkOutput("srt_st_outside_wait", ctrl2srt_srt_st, 0);
                upm2ctrl_pm_vld = 1'b0;
            end
            if (n == sort_cycles) begin
                checkOutput("no_early_done", leaf_done, 0);
                if (give_done) srt2ctrl_srt_done = 1'b1;
            end
            cyc();
            srt2ctrl_srt_done = 1'b0;
        end
        #1;
        checkOutput("sort_leaf_done", leaf_done, 1);
        checkOutput("sort_act", act_path_num, e_act);
        checkOutput("sort_err_to", err_to, m_err_to);
        cyc();
    endtask

    task automatic runFrozenLeaf(input logic [2:0] jt);
        if (jt > 3'd2) m_err_jt = 1'b1;
        leaf_req       = 1'b1;
        leaf_jump_type = jt;
        #1;
        checkOutput("frz_ack", leaf_ack, 1);
        checkOutput("frz_upm_req", ctrl2upm_req, 0);
        pushExpected(m_act, m_err_to, m_err_jt);
        cyc();
        leaf_req = 1'b0;
        #1;
        checkOutput("frz_done", leaf_done, 1);
        checkOutput("frz_srt_st", ctrl2srt_srt_st, 0);
        checkOutput("frz_act", act_path_num, m_act);
        checkOutput("frz_err_jt", err_jt, m_err_jt);
        checkOutput("frz_jt", cur_jump_type, jt);
        cyc();
        checkOutput("frz_done_single", leaf_done, 0);
    endtask

    initial begin
        rst_n             = 1'b0;
        frm_st            = 1'b0;
        leaf_req          = 1'b0;
        leaf_jump_type    = 3'd0;
        upm2ctrl_pm_vld   = 1'b0;
        srt2ctrl_srt_done = 1'b0;
        #12;
        checkOutput("rst_act", act_path_num, 1);
        checkOutput("rst_sort_num", sort_num, 0);
        checkOutput("rst_jt", cur_jump_type, 0);
        checkOutput("rst_pv", path_valid, 16'hFFFF);
        checkOutput("rst_err_to", err_to, 0);
        checkOutput("rst_err_jt", err_jt, 0);
        checkOutput("rst_pulses", {leaf_ack, leaf_done, ctrl2upm_req, ctrl2srt_srt_st}, 0);
        rst_n = 1'b1;
        cyc();
        frm_st = 1'b1;
        cyc();
        frm_st = 1'b0;

        // List growth: 1 -> 4 -> 8 (capped), then held at 8.
        applyStimulus(3'd2, 2, 3, 1'b1);
        applyStimulus(3'd2, 0, 1, 1'b1);
        applyStimulus(3'd2, 1, 5, 1'b1);
        applyStimulus(3'd1, 0, 2, 1'b1);

        runFrozenLeaf(3'd0);
        runFrozenLeaf(3'd5);

        srt2ctrl_srt_done = 1'b1;
        cyc();
        srt2ctrl_srt_done = 1'b0;
        #1;
        checkOutput("idle_done_ignored", {leaf_done, act_path_num}, {1'b0, m_act});
        cyc();

        // Sorter never answers: timeout, list size kept.
        applyStimulus(3'd1, 0, 64, 1'b0);

        frm_st = 1'b1;
        cyc();
        frm_st   = 1'b0;
        m_act    = 4'd1;
        m_err_to = 1'b0;
        m_err_jt = 1'b0;
        #1;
        checkOutput("frm_clear", {act_path_num, err_to, err_jt}, {4'd1, 2'b00});
        cyc();

        // Done on exactly the 64th SORT cycle beats the timeout.
        applyStimulus(3'd2, 0, 64, 1'b1);

        // Frame start during SORT (coinciding with done) aborts without leaf_done.
        leaf_req       = 1'b1;
        leaf_jump_type = 3'd2;
        #1;
        checkOutput("abort_ack", leaf_ack, 1);
        cyc();
        leaf_req        = 1'b0;
        upm2ctrl_pm_vld = 1'b1;
        cyc();
        upm2ctrl_pm_vld = 1'b0;
        cyc();
        frm_st            = 1'b1;
        srt2ctrl_srt_done = 1'b1;
        cyc();
        frm_st            = 1'b0;
        srt2ctrl_srt_done = 1'b0;
        m_act             = 4'd1;
        #1;
        checkOutput("abort_no_done", leaf_done, 0);
        checkOutput("abort_act", act_path_num, 1);
        cyc();
        runFrozenLeaf(3'd0);

        // Held request: acks on alternate cycles only.
        leaf_req       = 1'b1;
        leaf_jump_type = 3'd0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("b2b_ack", leaf_ack, (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) pushExpected(m_act, m_err_to, m_err_jt);
            cyc();
        end
        leaf_req = 1'b0;
        #1;
        checkOutput("b2b_last_done", leaf_done, 1);
        cyc();

        // Frame start in IDLE with a pending request: ack deferred one cycle.
        frm_st   = 1'b1;
        leaf_req = 1'b1;
        #1;
        checkOutput("frm_idle_no_ack", leaf_ack, 0);
        cyc();
        frm_st = 1'b0;
        #1;
        checkOutput("frm_idle_ack", leaf_ack, 1);
        pushExpected(m_act, m_err_to, m_err_jt);
        cyc();
        leaf_req = 1'b0;
        #1;
        checkOutput("frm_idle_done", leaf_done, 1);
        cyc();

        // Asynchronous reset while waiting for PMs.
        applyStimulus(3'd2, 0, 2, 1'b1);
        leaf_req       = 1'b1;
        leaf_jump_type = 3'd2;
        #1;
        checkOutput("ar_ack", leaf_ack, 1);
        cyc();
        leaf_req = 1'b0;
        #1;
        checkOutput("ar_cfg", {sort_num, path_valid}, {3'd3, 16'hFF55});
        rst_n = 1'b0;
        #1;
        checkOutput("ar_act", act_path_num, 1);
        checkOutput("ar_cfg_rst", {cur_jump_type, sort_num, path_valid}, {3'd0, 3'd0, 16'hFFFF});
        upm2ctrl_pm_vld = 1'b1;
        #1;
        checkOutput("ar_srt_st", ctrl2srt_srt_st, 0);
        upm2ctrl_pm_vld = 1'b0;
        #2;
        rst_n = 1'b1;
        m_act = 4'd1;
        cyc();
        runFrozenLeaf(3'd0);

        repeat (2) cyc();
        checkOutput("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
